// File: rtl/md4_hash_uart_tx.sv
// Collects a digest from the md4 output FIFO port and streams it as lowercase ASCII hex
// (optionally followed by CR LF) on an 8N1 UART transmit line.
module md4_hash_uart_tx #(
    parameter int HASH_SIZE    = 16,
    parameter int CLKS_PER_BIT = 738,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] HASH_BYTE,
    input  logic       HASH_WRITE,
    output logic       HASH_FULL,
    output logic       BUSY_OUT,
    output logic       DONE_OUT,
    output logic       ERROR_OUT,
    output logic       UART_TX
);

    localparam int NUM_CHARS = 2 * HASH_SIZE + (APPEND_CRLF ? 2 : 0);
    localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W     = (HASH_SIZE > 1) ? $clog2(HASH_SIZE) : 1;
    localparam int CHAR_W    = $clog2(NUM_CHARS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(HASH_SIZE - 1);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_CHARS - 1);
    localparam logic [CHAR_W-1:0] CHAR_CR   = CHAR_W'(2 * HASH_SIZE);

    typedef enum logic [2:0] {
        COLLECT,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t              state_q;
    logic [7:0]          hashBuf_q [HASH_SIZE];
    logic [IDX_W-1:0]    idx_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [2:0]          bit_q;
    logic [CHAR_W-1:0]   char_q;
    logic [6:0]          shift_q;
    logic                tx_q;
    logic                full_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [IDX_W-1:0]    byteSel;
    logic [7:0]          selByte;
    logic [3:0]          nibble;
    logic [7:0]          txChar;
    logic                accept;

    // Character currently being framed, derived from the character index.
    always_comb begin
        byteSel = IDX_W'(char_q >> 1);
        selByte = hashBuf_q[byteSel];
        nibble  = char_q[0] ? selByte[3:0] : selByte[7:4];
        if (char_q < CHAR_CR) begin
            txChar = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
        end else if (char_q == CHAR_CR) begin
            txChar = 8'h0D;
        end else begin
            txChar = 8'h0A;
        end
    end

    assign accept = HASH_WRITE && !full_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= COLLECT;
            for (int i = 0; i < HASH_SIZE; i++) begin
                hashBuf_q[i] <= 8'h00;
            end
            idx_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (HASH_WRITE && full_q) begin
                err_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        hashBuf_q[idx_q] <= HASH_BYTE;
                        busy_q           <= 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            full_q  <= 1'b1;
                            tx_q    <= 1'b0;
                            baud_q  <= '0;
                            char_q  <= '0;
                            state_q <= START_BIT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                START_BIT: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= txChar[0];
                        shift_q <= txChar[7:1];
                        state_q <= DATA_BITS;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[6:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP_BIT: begin
                    // Next start bit follows immediately so characters run back-to-back.
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (char_q == CHAR_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            char_q  <= char_q + 1'b1;
                            tx_q    <= 1'b0;
                            state_q <= START_BIT;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    full_q  <= 1'b0;
                    idx_q   <= '0;
                    char_q  <= '0;
                    state_q <= COLLECT;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign HASH_FULL = full_q;
    assign BUSY_OUT  = busy_q;
    assign DONE_OUT  = done_q;
    assign ERROR_OUT = err_q;
    assign UART_TX   = tx_q;

endmodule

// File: tb/tb_md4_hash_uart_tx.sv
// Scoreboard bench for md4_hash_uart_tx: two instances (with and without CR LF), UART decoded
// by per-instance monitors and compared against a hex-string reference of each written digest.
module tb_md4_hash_uart_tx;

    localparam int CPB = 4;

    typedef logic [7:0] digest_t [16];

    logic       clk = 1'b0;
    logic       rst       [2];
    logic [7:0] hashByte  [2];
    logic       hashWrite [2];
    logic       hashFull  [2];
    logic       busy      [2];
    logic       done      [2];
    logic       err       [2];
    logic       uartTx    [2];

    int checks = 0;
    int errors = 0;
    int epoch [2];
    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];

    always #5 clk = ~clk;

    md4_hash_uart_tx #(.HASH_SIZE(16), .CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b1)) dutCrlf (
        .CLK(clk), .RESET(rst[0]), .HASH_BYTE(hashByte[0]), .HASH_WRITE(hashWrite[0]),
        .HASH_FULL(hashFull[0]), .BUSY_OUT(busy[0]), .DONE_OUT(done[0]),
        .ERROR_OUT(err[0]), .UART_TX(uartTx[0])
    );

    md4_hash_uart_tx #(.HASH_SIZE(16), .CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b0)) dutHex (
        .CLK(clk), .RESET(rst[1]), .HASH_BYTE(hashByte[1]), .HASH_WRITE(hashWrite[1]),
        .HASH_FULL(hashFull[1]), .BUSY_OUT(busy[1]), .DONE_OUT(done[1]),
        .ERROR_OUT(err[1]), .UART_TX(uartTx[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference frame: the digest as a lowercase hex string, plus CR LF on instance 0.
    function automatic string frameText(input int inst, input digest_t d);
        string s = "";
        for (int i = 0; i < 16; i++) s = {s, $sformatf("%02x", d[i])};
        if (inst == 0) s = {s, "\r\n"};
        return s;
    endfunction

    function automatic void pushExpected(input int inst, input digest_t d);
        string s = frameText(inst, d);
        for (int i = 0; i < s.len(); i++) begin
            if (inst == 0) expQ0.push_back(s[i]);
            else expQ1.push_back(s[i]);
        end
    endfunction

    // Writes one digest with optional random idle gaps; returns just after the last accept edge.
    task automatic applyStimulus(input int inst, input digest_t d, input int maxGap);
        int idleBad = 0;
        int busyBad = 0;
        pushExpected(inst, d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, maxGap)) begin
                hashWrite[inst] = 1'b0;
                hashByte[inst]  = 'x;
                @(posedge clk);
                #1;
                if (uartTx[inst] !== 1'b1 || hashFull[inst] !== 1'b0) idleBad++;
            end
            hashWrite[inst] = 1'b1;
            hashByte[inst]  = d[i];
            @(posedge clk);
            #1;
            hashWrite[inst] = 1'b0;
            hashByte[inst]  = 'x;
            if (busy[inst] !== 1'b1) busyBad++;
            if (i < 15 && (uartTx[inst] !== 1'b1 || hashFull[inst] !== 1'b0)) idleBad++;
        end
        checkOutput("idleBeforeLastByte", idleBad, 0);
        checkOutput("busyAfterAccept", busyBad, 0);
        checkOutput("fullOnLastAccept", hashFull[inst], 1'b1);
        checkOutput("txFallsOnLastAccept", uartTx[inst], 1'b0);
    endtask

    // Follows a frame to its DONE pulse, checking the first character waveform cycle by cycle.
    task automatic waitDone(input int inst, input digest_t d, input int glitchAt);
        string s = frameText(inst, d);
        logic [7:0] fc = s[0];
        int expCycles = s.len() * 10 * CPB;
        int cnt = 0;
        int waveBad = 0;
        int k;
        logic expBit;
        forever begin
            hashWrite[inst] = (cnt == glitchAt);
            hashByte[inst]  = (cnt == glitchAt) ? 8'hff : 'x;
            if (cnt < 10 * CPB) begin
                k = cnt / CPB;
                expBit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fc[k-1];
                if (uartTx[inst] !== expBit) waveBad++;
            end
            if (done[inst] === 1'b1 || cnt >= 3000) break;
            @(posedge clk);
            #1;
            cnt++;
        end
        hashWrite[inst] = 1'b0;
        hashByte[inst]  = 'x;
        checkOutput("firstCharWave", waveBad, 0);
        checkOutput("doneLatency", cnt, expCycles);
        checkOutput("fullInDoneCycle", hashFull[inst], 1'b1);
        checkOutput("busyInDoneCycle", busy[inst], 1'b1);
        @(posedge clk);
        #1;
        checkOutput("donePulseEnds", done[inst], 1'b0);
        checkOutput("busyClears", busy[inst], 1'b0);
        checkOutput("fullClears", hashFull[inst], 1'b0);
        checkOutput("txIdleAfterFrame", uartTx[inst], 1'b1);
    endtask

    // One UART decoder per instance; characters cut short by a reset are discarded.
    for (genvar g = 0; g < 2; g++) begin : monitor
        initial begin
            int ep;
            logic [7:0] ch;
            logic startBit;
            logic stopBit;
            logic [7:0] expCh;
            logic haveExp;
            forever begin
                @(negedge clk);
                if (uartTx[g] === 1'b0) begin
                    ep = epoch[g];
                    repeat (CPB / 2) @(negedge clk);
                    startBit = uartTx[g];
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        ch[i] = uartTx[g];
                    end
                    repeat (CPB) @(negedge clk);
                    stopBit = uartTx[g];
                    if (ep == epoch[g]) begin
                        haveExp = 1'b0;
                        expCh   = 8'h00;
                        if (g == 0 && expQ0.size() > 0) begin
                            expCh = expQ0.pop_front();
                            haveExp = 1'b1;
                        end else if (g == 1 && expQ1.size() > 0) begin
                            expCh = expQ1.pop_front();
                            haveExp = 1'b1;
                        end
                        checkOutput("uartCharExpected", haveExp, 1'b1);
                        checkOutput("uartStartBit", startBit, 1'b0);
                        checkOutput("uartChar", ch, expCh);
                        checkOutput("uartStopBit", stopBit, 1'b1);
                    end
                end
            end
        end
    end

    initial begin
        digest_t vec1 = '{8'h2b, 8'haa, 8'h06, 8'h45, 8'he8, 8'hc3, 8'h3c, 8'h14,
                          8'h02, 8'h27, 8'h16, 8'he6, 8'hda, 8'h14, 8'hb8, 8'h1c};
        digest_t vecSeq;
        digest_t vecRnd;
        for (int i = 0; i < 16; i++) vecSeq[i] = 8'(i);
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            hashWrite[i] = 1'b0;
            hashByte[i]  = 8'h00;
            epoch[i]     = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("resetTx", uartTx[i], 1'b1);
            checkOutput("resetFull", hashFull[i], 1'b0);
            checkOutput("resetBusy", busy[i], 1'b0);
            checkOutput("resetDone", done[i], 1'b0);
            checkOutput("resetError", err[i], 1'b0);
            rst[i] = 1'b0;
        end

        $display("[TB] known digest with CR LF");
        applyStimulus(0, vec1, 0);
        waitDone(0, vec1, -1);

        $display("[TB] write attempt during a frame");
        checkOutput("errorClearBeforeGlitch", err[0], 1'b0);
        applyStimulus(0, vec1, 0);
        waitDone(0, vec1, 300);
        checkOutput("errorSetByGlitch", err[0], 1'b1);

        $display("[TB] known digest with random write gaps");
        applyStimulus(0, vec1, 5);
        waitDone(0, vec1, -1);
        checkOutput("errorSticky", err[0], 1'b1);

        $display("[TB] reset during the fifth character");
        applyStimulus(0, vec1, 0);
        repeat (4 * 10 * CPB + 15) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        epoch[0]++;
        expQ0.delete();
        #1;
        checkOutput("midFrameResetTx", uartTx[0], 1'b1);
        checkOutput("midFrameResetFull", hashFull[0], 1'b0);
        checkOutput("midFrameResetBusy", busy[0], 1'b0);
        checkOutput("midFrameResetError", err[0], 1'b0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        repeat (50) @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) vecRnd[i] = 8'($urandom);
            applyStimulus(0, vecRnd, 3);
            waitDone(0, vecRnd, -1);
        end

        $display("[TB] hex-only instance, back-to-back digests");
        applyStimulus(1, vecSeq, 0);
        waitDone(1, vecSeq, -1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) vecRnd[i] = 8'($urandom);
            applyStimulus(1, vecRnd, (r == 0) ? 0 : 5);
            waitDone(1, vecRnd, -1);
        end
        checkOutput("hexOnlyNoError", err[1], 1'b0);

        repeat (20) @(posedge clk);
        checkOutput("queueDrainedCrlf", expQ0.size(), 0);
        checkOutput("queueDrainedHex", expQ1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
